// File: rtl/demux_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_sequencer_if
// Brief    : Word-in / demux-out signal bundle for demux_sequencer.
// Revision : 1.0
// ============================================================================
interface demux_sequencer_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       din;
    logic             din_valid;
    logic             din_ready;
    logic             mode;
    logic [1:0]       ch_in;
    logic             abort;
    logic [1:0]       a;
    logic [1:0]       sel;
    logic             out_valid;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] word_cnt;

    // Upstream source side.
    modport master (
        output din, din_valid, mode, ch_in, abort,
        input  din_ready, a, sel, out_valid, rr_ptr, word_cnt
    );

    // Sequencer side.
    modport slave (
        input  din, din_valid, mode, ch_in, abort,
        output din_ready, a, sel, out_valid, rr_ptr, word_cnt
    );
endinterface
`default_nettype wire

// File: rtl/demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demux_sequencer
// Brief    : Feeds a 1-to-4 demux; each accepted word is held for a fixed
//            dwell on a round-robin or tagged channel, then one idle cycle.
// Revision : 1.0
// ============================================================================
module demux_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    demux_sequencer_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] c_hold_load = 8'(HOLD_CYCLES - 1);

    state_t           r_state,     w_state_nxt;
    logic [1:0]       r_a,         w_a_nxt;
    logic [1:0]       r_sel,       w_sel_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_din_ready, w_din_ready_nxt;
    logic [1:0]       r_rr_ptr,    w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_word_cnt,  w_word_cnt_nxt;
    logic [7:0]       r_hold_cnt,  w_hold_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= 2'b00;
            r_sel       <= 2'b00;
            r_out_valid <= 1'b0;
            r_din_ready <= 1'b0;
            r_rr_ptr    <= 2'b00;
            r_word_cnt  <= '0;
            r_hold_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_sel       <= w_sel_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_din_ready <= w_din_ready_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_sel_nxt       = r_sel;
        w_out_valid_nxt = r_out_valid;
        w_din_ready_nxt = r_din_ready;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_word_cnt_nxt  = r_word_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;

        case (r_state)
            IDLE: begin
                // DIN/CH_IN are only looked at here, so X elsewhere never reaches A/SEL.
                if (bus.din_valid && r_din_ready) begin
                    w_a_nxt         = bus.din;
                    w_sel_nxt       = bus.mode ? bus.ch_in : r_rr_ptr;
                    w_rr_ptr_nxt    = bus.mode ? r_rr_ptr : r_rr_ptr + 2'd1;
                    w_out_valid_nxt = 1'b1;
                    w_din_ready_nxt = 1'b0;
                    w_hold_cnt_nxt  = c_hold_load;
                    w_word_cnt_nxt  = r_word_cnt + 1'b1;
                    w_state_nxt     = HOLD;
                end else begin
                    w_din_ready_nxt = 1'b1;
                end
            end
            HOLD: begin
                // SEL stays put so the demux drives zero on the channel just used.
                if (r_hold_cnt == 8'd0 || bus.abort) begin
                    w_out_valid_nxt = 1'b0;
                    w_a_nxt         = 2'b00;
                    w_din_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_hold_cnt_nxt  = r_hold_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.a         = r_a;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.din_ready = r_din_ready;
    assign bus.rr_ptr    = r_rr_ptr;
    assign bus.word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_sequencer
// Brief    : Directed and random stimulus against a word-level dwell model.
// Revision : 1.0
// ============================================================================
module tb_demux_sequencer;

    localparam int HOLD = 4;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_sequencer_if #(.CNT_W(CW)) bus();

    demux_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: a word is "on air" for m_left more cycles; nothing more.
    int m_a, m_sel, m_valid, m_ready, m_rr, m_cnt, m_left;
    bit m_acc;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_sel = 0; m_valid = 0; m_ready = 0;
        m_rr = 0; m_cnt = 0; m_left = 0; m_acc = 0;
    endtask

    task automatic model_edge();
        m_acc = 0;
        if (rst) begin
            model_reset();
        end else if (m_valid == 0) begin
            if (bus.din_valid && m_ready == 1) begin
                m_acc   = 1;
                m_a     = int'(bus.din);
                m_sel   = bus.mode ? int'(bus.ch_in) : m_rr;
                if (!bus.mode) m_rr = (m_rr + 1) % 4;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_valid = 1;
                m_ready = 0;
                m_left  = HOLD;
            end else begin
                m_ready = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0 || bus.abort) begin
                m_valid = 0;
                m_a     = 0;
                m_ready = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("a",         int'(bus.a),         m_a);
        check("sel",       int'(bus.sel),       m_sel);
        check("out_valid", int'(bus.out_valid), m_valid);
        check("din_ready", int'(bus.din_ready), m_ready);
        check("rr_ptr",    int'(bus.rr_ptr),    m_rr);
        check("word_cnt",  int'(bus.word_cnt),  m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Advance until the model accepts a word; an expired bound is a failure.
    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 50);
        check({tag, "_accept_timeout"}, int'(m_acc), 1);
    endtask

    initial begin
        int words [4];
        int idx, n, rr_before;

        bus.din = 2'b00; bus.din_valid = 1'b0; bus.mode = 1'b0;
        bus.ch_in = 2'b00; bus.abort = 1'b0;
        model_reset();

        // Reset held for 3 cycles, then one edge to raise din_ready.
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        check("ready_after_reset", int'(bus.din_ready), 1);

        // Round-robin burst with the source holding din_valid.
        words = '{1, 2, 3, 1};
        idx = 0;
        bus.mode = 1'b0; bus.din = 2'(words[0]); bus.din_valid = 1'b1;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            tick();
            if (m_acc) begin
                check("rr_sel_seq", int'(bus.sel), idx);
                check("rr_a_seq",   int'(bus.a),   words[idx]);
                idx++;
                if (idx < 4) bus.din = 2'(words[idx]);
                else         bus.din_valid = 1'b0;
            end
        end
        check("rr_words_sent", idx, 4);
        for (int c = 0; c < 10 && bus.out_valid; c++) tick();
        tick();
        check("rr_ptr_wrapped", int'(bus.rr_ptr), 0);
        check("rr_word_cnt",    int'(bus.word_cnt), 4);

        // Explicit channel.
        rr_before = m_rr;
        bus.mode = 1'b1; bus.ch_in = 2'b10; bus.din = 2'b11; bus.din_valid = 1'b1;
        wait_accept("explicit");
        bus.din_valid = 1'b0; bus.din = 2'b00; bus.ch_in = 2'b00;
        check("explicit_a",   int'(bus.a),   3);
        check("explicit_sel", int'(bus.sel), 2);
        n = 0;
        while (bus.out_valid && n < 20) begin n++; tick(); end
        check("explicit_dwell", n, HOLD);
        check("explicit_rr_kept", int'(bus.rr_ptr), rr_before);

        // Abort on the second dwell cycle.
        bus.mode = 1'b0; bus.din = 2'b01; bus.din_valid = 1'b1;
        wait_accept("abort");
        bus.din_valid = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_valid", int'(bus.out_valid), 0);
        check("abort_a",     int'(bus.a),         0);
        check("abort_ready", int'(bus.din_ready), 1);
        tick();

        // Asynchronous reset during the third dwell cycle on channel 2.
        bus.mode = 1'b1; bus.ch_in = 2'b10; bus.din = 2'b11; bus.din_valid = 1'b1;
        wait_accept("midreset");
        bus.din_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async_rst_a",     int'(bus.a),         0);
        check("async_rst_sel",   int'(bus.sel),       0);
        check("async_rst_valid", int'(bus.out_valid), 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        bus.mode = 1'b0; bus.din = 2'b10; bus.din_valid = 1'b1;
        wait_accept("post_reset");
        check("post_reset_sel", int'(bus.sel), 0);
        bus.din_valid = 1'b0;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            bus.din       = 2'($urandom_range(0, 3));
            bus.din_valid = ($urandom_range(0, 3) != 0);
            bus.mode      = 1'($urandom_range(0, 1));
            bus.ch_in     = 2'($urandom_range(0, 3));
            bus.abort     = ($urandom_range(0, 5) == 0);
            tick();
        end
        bus.abort = 1'b0; bus.din_valid = 1'b0;

        // Counter wrap over 256 round-robin words.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.mode = 1'b0; bus.din_valid = 1'b1;
        n = 0;
        while (m_cnt != 255 && n < 3000) begin
            bus.din = 2'($urandom_range(0, 3));
            tick();
            n++;
        end
        check("wrap_cnt_255", int'(bus.word_cnt), 255);
        wait_accept("wrap");
        check("wrap_cnt_0",  int'(bus.word_cnt), 0);
        check("wrap_rr_ptr", int'(bus.rr_ptr),   0);
        bus.din_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
